// File: rtl/tpu_pkg.sv
// Shared TPU types: byte and weight-buffer address widths plus fetcher state encoding.
package tpu_pkg;

    localparam int BYTE_WIDTH           = 8;
    localparam int WEIGHT_ADDRESS_WIDTH = 15;
    localparam int LENGTH_WIDTH         = 16;

    typedef logic [BYTE_WIDTH-1:0]           byte_type;
    typedef logic [WEIGHT_ADDRESS_WIDTH-1:0] weight_addr_type;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    // Row address increment with wrap at the end of the tile buffer.
    function automatic weight_addr_type next_weight_addr(input weight_addr_type addr,
                                                          input int unsigned     tile_width);
        if (addr == weight_addr_type'(tile_width - 1))
            return '0;
        return addr + weight_addr_type'(1);
    endfunction

endpackage

// File: rtl/weight_fetcher.sv
// Streams a run of weight rows from the tile buffer to the matrix unit, tracking
// the buffer's read pipeline with a valid/last tag shift register and honouring backpressure.
module weight_fetcher
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH = 14,
    parameter int TILE_WIDTH   = 32768,
    parameter int READ_LATENCY = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    input  weight_addr_type                instr_addr,
    input  logic [LENGTH_WIDTH-1:0]        instr_length,
    output weight_addr_type                buf_addr,
    output logic                           buf_en,
    output logic                           buf_enable,
    input  byte_type [MATRIX_WIDTH-1:0]    buf_read_data,
    output byte_type [MATRIX_WIDTH-1:0]    weight_data,
    output logic                           weight_valid,
    output logic                           weight_last,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    fetch_state_t              r_state;
    fetch_state_t              w_state_next;
    weight_addr_type           r_addr;
    logic [LENGTH_WIDTH-1:0]   r_remaining;
    logic [READ_LATENCY-1:0]   r_tag_valid;
    logic [READ_LATENCY-1:0]   r_tag_last;
    logic                      r_done;

    logic w_stall;
    logic w_accept;
    logic w_accept_run;
    logic w_issue;
    logic w_last_issue;
    logic w_last_xfer;

    assign weight_valid = r_tag_valid[READ_LATENCY-1];
    assign weight_last  = r_tag_last[READ_LATENCY-1];
    assign weight_data  = buf_read_data;

    assign w_stall      = weight_valid & ~out_ready;
    assign w_accept     = instr_valid & (r_state == S_IDLE);
    assign w_accept_run = w_accept & (instr_length != '0);
    assign w_issue      = (r_state == S_ISSUE) & ~w_stall;
    assign w_last_issue = w_issue & (r_remaining == LENGTH_WIDTH'(1));
    assign w_last_xfer  = weight_valid & out_ready & weight_last;

    assign instr_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign buf_en      = w_issue;
    assign buf_addr    = r_addr;
    // The buffer pipeline must not advance while reset is held, even though it sits outside this reset domain.
    assign buf_enable  = ~rst & ~w_stall;
    assign done        = r_done;

    always_comb begin
        // NOTE: default assignment first so every path drives w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept_run) w_state_next = S_ISSUE;
            S_ISSUE: if (w_last_issue) w_state_next = S_DRAIN;
            S_DRAIN: if (w_last_xfer)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_tag_valid <= '0;
            r_tag_last  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_accept & (instr_length == '0)) | w_last_xfer;

            if (w_accept_run) begin
                r_addr      <= instr_addr;
                r_remaining <= instr_length;
            end else if (w_issue) begin
                r_addr      <= next_weight_addr(r_addr, TILE_WIDTH);
                r_remaining <= r_remaining - LENGTH_WIDTH'(1);
            end

            // Tags move in lock-step with the buffer's own output pipeline.
            if (!w_stall) begin
                r_tag_valid <= (r_tag_valid << 1) | READ_LATENCY'(w_issue);
                r_tag_last  <= (r_tag_last  << 1) | READ_LATENCY'(w_last_issue);
            end
        end
    end

endmodule

// File: doc/weight_fetcher.md
WEIGHT_FETCHER -- requirements
Module: weight_fetcher

Interface
REQ-001 Parameters SHALL be: MATRIX_WIDTH, default 14, bytes per weight row; TILE_WIDTH, default 32768, buffer depth in rows; READ_LATENCY, default 3, cycles from buf_en to data at buf_read_data.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; the ports SHALL be named clk and rst.
REQ-003 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- instr_valid  in  1  fetch instruction offered.
- instr_ready  out  1  block idle, instruction accepted when high with instr_valid.
- instr_addr  in  weight_addr_type  first buffer row.
- instr_length  in  LENGTH_WIDTH  rows to fetch; 0 is a no-op.
- buf_addr  out  weight_addr_type  buffer read address.
- buf_en  out  1  buffer port read enable.
- buf_enable  out  1  buffer output-pipeline advance.
- buf_read_data  in  byte_type[MATRIX_WIDTH]  buffer read port.
- weight_data  out  byte_type[MATRIX_WIDTH]  row to matrix unit.
- weight_valid  out  1  weight_data valid.
- weight_last  out  1  final row of instruction.
- out_ready  in  1  downstream accepts row.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse when instruction completes.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE and DRAIN.
REQ-005 Instruction acceptance: instr_ready SHALL equal (state==IDLE).
- Accept in IDLE with instr_valid and instr_length>0 -> latch addr/length, go to ISSUE.
- Accept with length 0 -> stay IDLE, pulse done next cycle, no reads.
REQ-006 In ISSUE, when not stalled, the block SHALL assert buf_en=1 with buf_addr = current address, then advance the address by 1 and decrement the remaining-issue count.
REQ-007 When the last read has been issued, the FSM SHALL go to DRAIN.
REQ-008 Address wrap: the address SHALL wrap from TILE_WIDTH-1 to 0.
REQ-009 A READ_LATENCY-deep valid/last tag shift register SHALL mirror the buffer pipeline.
- It shifts only when buf_enable=1.
- A tag enters with each issued read.
- weight_valid and weight_last are the final stage; weight_data = buf_read_data (combinational passthrough).
REQ-010 stall = weight_valid & ~out_ready. During a stall:
- buf_en=0 and buf_enable=0.
- Address, counters, tags and buffer pipeline frozen; weight_data and weight_valid held stable.
REQ-011 When not stalled, buf_enable SHALL be 1 in all states, so drain continues in DRAIN.
REQ-012 A row transfers when weight_valid & out_ready.
- The transfer with weight_last=1 SHALL cause done=1 next cycle and a return to IDLE.
REQ-013 weight_last SHALL be set only on the tag of the final issued read.
REQ-014 With no stalls, N rows SHALL issue in N consecutive cycles.
- The first weight_valid appears READ_LATENCY cycles after the first buf_en.
- Throughput is one row per cycle.
REQ-015 busy SHALL equal (state!=IDLE).
REQ-016 instr_valid outside IDLE SHALL be ignored.

Reset
REQ-017 Reset SHALL force:
- state IDLE, address 0, counters 0, all tags 0.
- buf_en=0, buf_enable=0, weight_valid=0, weight_last=0, done=0, busy=0, instr_ready=1.
REQ-018 Reset mid-instruction SHALL abandon it with no done pulse.
- The first cycle after reset release SHALL accept a new instruction.

Structure
REQ-019 weight_addr_type, byte_type, BYTE_WIDTH, WEIGHT_ADDRESS_WIDTH and LENGTH_WIDTH SHALL live in tpu_pkg.
REQ-020 The block SHALL be a single module with no sub-modules; the tag shift register is inline.

Verification
REQ-021 Basic fetch: addr=0, length=14, out_ready=1.
- buf_addr 0..13 on 14 consecutive cycles.
- 14 valid rows starting 3 cycles after the first buf_en; last on the 14th row; done one cycle later.
REQ-022 Address wrap: addr=32766, length=4 -> buf_addr sequence 32766, 32767, 0, 1.
REQ-023 Backpressure: length=6, out_ready low for 5 cycles while row 2 is valid.
- weight_data stable during the stall, buf_en=0.
- All 6 rows delivered in order, no duplicates or drops.
REQ-024 Length 0 -> no buf_en, done pulse 1 cycle after accept, instr_ready stays high.
REQ-025 Reset mid-operation: rst asserted in DRAIN with 2 rows pending.
- Outputs immediately 0, no done pulse.
- A following instruction with length=3 completes correctly.
